photon_ipi_histogrammer: RTL and testbench
==========================================

// Module: photon_ipi_histogrammer
// PURPOSE
//  Parametrised per-channel photon counter and inter-photon-interval (IPI) histogrammer for the LVDS bin inputs.
//  Detects photons on NCH channels, applies a programmable dead-time veto and drives two masked coincidence outputs.
//  Counts hits per channel and histograms the cycle gap between accepted photons, with an overflow bin.
//  Counters are read through a sequential address/valid port, so no array outputs. Sits in the clkin domain, after the LVDS receiver.
// PARAMETERS
//  NCH   8   number of photon input channels
//  NIPI  64  number of IPI bins (gaps 0..NIPI-1 cycles); one extra overflow bin
//  CW    32  width of every histogram counter
//  VW    8   width of the dead-time counter and the cyclestoveto input
// PORTS
//  clkin        in   1                      single clock; all logic is on its rising edge
//  resethist    in   1                      reset, synchronous, active-high
//  lvds_rx      in   NCH                    raw photon levels, one bit per channel
//  mask1        in   NCH                    channel select for out1
//  mask2        in   NCH                    channel select for out2
//  edgemode     in   1                      1: count rising edges only; 0: count levels
//  passthrough  in   1                      1: bypass veto/counting; outs follow raw masked inputs
//  cyclestoveto in   VW                     dead-time length in cycles after an accepted photon
//  freeze       in   1                      1: histograms hold their values; outputs keep running
//  rd_req       in   1                      read strobe
//  rd_addr      in   $clog2(NCH+NIPI+1)     read address (map below)
//  rd_valid     out  1                      rd_data valid, one cycle after rd_req
//  rd_data      out  CW                     counter value read
//  out1, out2   out  1                      registered coincidence outputs
//  inveto       out  1                      registered; 1 while the dead-time window is active
//  collision    out  1                      one-cycle pulse: a photon was vetoed by dead-time
// BEHAVIOUR
//  Reset (resethist=1 at an edge): every counter=0, rx_d=0, gapcnt=2^VW-1, seen_first=0.
//   Also out1=out2=inveto=collision=rd_valid=0 and rd_data=0. Reset overrides all other inputs, including an increment or read in that cycle.
//  raw = edgemode ? (lvds_rx & ~rx_d) : lvds_rx; rx_d <= lvds_rx every cycle.
//  veto = (gapcnt < cyclestoveto); phot = veto ? 0 : raw (combinational).
//  gapcnt: if phot!=0 then 0, else gapcnt+1, saturating at 2^VW-1.
//  inveto <= veto. collision <= veto & (raw!=0).
//  out1 <= |(phot & mask1); out2 <= |(phot & mask2). Latency: 1 cycle from lvds_rx to out.
//  passthrough=1: out1 <= |(lvds_rx&mask1), out2 <= |(lvds_rx&mask2).
//   While passthrough=1, gapcnt, seen_first and all counters hold; rx_d still updates.
//  Channel counts (freeze=0): cnt[j] += phot[j], for every channel in the same cycle. Multi-channel photons count once per channel.
//  IPI (freeze=0, phot!=0): if seen_first, then ipi[gapcnt]++ when gapcnt<NIPI, else ovf++.
//   Whenever phot!=0, seen_first <= 1. The first photon after reset records no IPI.
//  All counters saturate at 2^CW-1; they never wrap.
//  Address map: 0..NCH-1 = cnt[j]; NCH..NCH+NIPI-1 = ipi[a-NCH]; NCH+NIPI = ovf.
//   Addresses above NCH+NIPI read 0.
//  Read: rd_req at edge k -> rd_valid=1 with rd_data at edge k+1. rd_valid=0 otherwise; rd_data holds.
//   A read colliding with an increment of the same counter returns the pre-increment value. Back-to-back reads allowed every cycle.
//  freeze only gates counter updates. Veto, gapcnt and the outputs behave normally while frozen.
// TESTING
//  1. Reset, then a single pulse on ch2, edgemode=1, mask1=0x04 -> out1=1 exactly 1 cycle later; read addr 2 -> 1.
//  2. cyclestoveto=5; photons on ch0 at cycles 0,3,10 -> cycle-3 photon vetoed with collision=1.
//     Then ipi[9]=1 (addr NCH+9), cnt[0]=2.
//  3. Gap of 200 cycles with NIPI=64 -> ovf=1. Level-mode held input with cyclestoveto=0 -> ipi[0] increments every cycle.
//  4. Force cnt[0]=2^CW-2 (CW=8 build), then 3 photons -> cnt[0]=255, no wrap.
//  5. freeze=1 during a burst -> counters unchanged, out1/out2 still pulse.
//     Reset mid-burst -> all reads return 0 and the next photon records no IPI.
//  6. passthrough=1 with lvds_rx=0x81 held, mask2=0x80 -> out2=1 each cycle; counters remain 0.

Source files
------------

// File: rtl/photon_ipi_histogrammer.sv
// Per-channel photon counter and inter-photon-interval histogrammer with dead-time veto,
// masked coincidence outputs and a sequential address/valid readout port.

module photon_ipi_satcnt #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)                 q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
  end
endmodule

module photon_ipi_lane #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          edgemode,
  input  logic          veto,
  input  logic          cnt_en,
  output logic          raw,
  output logic          phot,
  output logic [CW-1:0] cnt
);
  logic rx_d;

  always_ff @(posedge clk) begin
    if (rst) rx_d <= 1'b0;
    else     rx_d <= rx;
  end

  assign raw  = edgemode ? (rx & ~rx_d) : rx;
  assign phot = raw & ~veto;

  photon_ipi_satcnt #(.CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_en & phot),
    .q   (cnt)
  );
endmodule

module photon_ipi_histogrammer #(
  parameter int NCH  = 8,
  parameter int NIPI = 64,
  parameter int CW   = 32,
  parameter int VW   = 8,
  parameter int AW   = $clog2(NCH + NIPI + 1)
) (
  input  logic           clkin,
  input  logic           resethist,
  input  logic [NCH-1:0] lvds_rx,
  input  logic [NCH-1:0] mask1,
  input  logic [NCH-1:0] mask2,
  input  logic           edgemode,
  input  logic           passthrough,
  input  logic [VW-1:0]  cyclestoveto,
  input  logic           freeze,
  input  logic           rd_req,
  input  logic [AW-1:0]  rd_addr,
  output logic           rd_valid,
  output logic [CW-1:0]  rd_data,
  output logic           out1,
  output logic           out2,
  output logic           inveto,
  output logic           collision
);
  localparam int NBIN = NCH + NIPI + 1;
  localparam logic [AW:0] LAST = (AW+1)'(NBIN - 1);

  logic [NCH-1:0]           raw, phot;
  logic [VW-1:0]            gapcnt;
  logic                     seen_first;
  logic                     veto, any_phot, cnt_en, ipi_hit, ovf_inc;
  logic [NIPI-1:0]          ipi_inc;
  logic [NBIN-1:0][CW-1:0]  bank;

  assign veto     = gapcnt < cyclestoveto;
  assign any_phot = |phot;
  // Passthrough freezes all histogram state, freeze only the counters.
  assign cnt_en   = ~freeze & ~passthrough;
  assign ipi_hit  = cnt_en & any_phot & seen_first;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      photon_ipi_lane #(.CW(CW)) u_lane (
        .clk      (clkin),
        .rst      (resethist),
        .rx       (lvds_rx[g]),
        .edgemode (edgemode),
        .veto     (veto),
        .cnt_en   (cnt_en),
        .raw      (raw[g]),
        .phot     (phot[g]),
        .cnt      (bank[g])
      );
    end

    for (g = 0; g < NIPI; g++) begin : g_ipi
      assign ipi_inc[g] = ipi_hit && (gapcnt == VW'(g));
      photon_ipi_satcnt #(.CW(CW)) u_bin (
        .clk (clkin),
        .rst (resethist),
        .inc (ipi_inc[g]),
        .q   (bank[NCH+g])
      );
    end
  endgenerate

  // No in-range bin matched, so the gap is beyond the histogram.
  assign ovf_inc = ipi_hit & ~(|ipi_inc);

  photon_ipi_satcnt #(.CW(CW)) u_ovf (
    .clk (clkin),
    .rst (resethist),
    .inc (ovf_inc),
    .q   (bank[NCH+NIPI])
  );

  always_ff @(posedge clkin) begin
    if (resethist) begin
      gapcnt     <= '1;
      seen_first <= 1'b0;
    end else if (!passthrough) begin
      if (any_phot)        gapcnt <= '0;
      else if (gapcnt != '1) gapcnt <= gapcnt + 1'b1;
      if (any_phot)        seen_first <= 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (resethist) begin
      out1      <= 1'b0;
      out2      <= 1'b0;
      inveto    <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (passthrough) begin
        out1 <= |(lvds_rx & mask1);
        out2 <= |(lvds_rx & mask2);
      end else begin
        out1 <= |(phot & mask1);
        out2 <= |(phot & mask2);
      end
      inveto    <= veto;
      collision <= veto & (|raw);
    end
  end

  // Reads sample the bank before this edge's increments land.
  always_ff @(posedge clkin) begin
    if (resethist) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= ({1'b0, rd_addr} <= LAST) ? bank[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_photon_ipi_histogrammer.sv
// Scoreboarded bench for photon_ipi_histogrammer: reads push expected values,
// a negedge monitor pops and compares whenever rd_valid is seen.

module tb_photon_ipi_histogrammer;
  localparam int NCH = 8, NIPI = 64, CW = 8, VW = 8;
  localparam int AW  = $clog2(NCH + NIPI + 1);
  localparam int OVF = NCH + NIPI;

  logic           clkin = 1'b0;
  logic           resethist;
  logic [NCH-1:0] lvds_rx, mask1, mask2;
  logic           edgemode, passthrough, freeze, rd_req;
  logic [VW-1:0]  cyclestoveto;
  logic [AW-1:0]  rd_addr;
  logic           rd_valid, out1, out2, inveto, collision;
  logic [CW-1:0]  rd_data;

  int checks = 0, errors = 0;
  logic [CW-1:0] expq[$];
  string         nameq[$];
  logic [CW-1:0] mon_e;
  string         mon_n;

  always #5 clkin = ~clkin;

  photon_ipi_histogrammer #(.NCH(NCH), .NIPI(NIPI), .CW(CW), .VW(VW)) dut (
    .clkin(clkin), .resethist(resethist), .lvds_rx(lvds_rx), .mask1(mask1), .mask2(mask2),
    .edgemode(edgemode), .passthrough(passthrough), .cyclestoveto(cyclestoveto),
    .freeze(freeze), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .out1(out1), .out2(out2), .inveto(inveto), .collision(collision)
  );

  always @(negedge clkin) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 with no read pending, data=%0d", rd_data);
      end else begin
        mon_e = expq.pop_front();
        mon_n = nameq.pop_front();
        if (rd_data !== mon_e) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", mon_n, rd_data, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clkin); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic rd(input int a, input int exp, input string name);
    rd_req  = 1'b1;
    rd_addr = a[AW-1:0];
    expq.push_back(exp[CW-1:0]);
    nameq.push_back(name);
    step();
    rd_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin step(); n++; end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL rd_timeout: got %0d pending reads expected 0", expq.size());
      expq.delete(); nameq.delete();
    end
  endtask

  task automatic do_reset();
    resethist = 1'b1;
    step(); step();
    resethist = 1'b0;
  endtask

  task automatic hold(input logic [NCH-1:0] v, input int n);
    lvds_rx = v;
    repeat (n) step();
    lvds_rx = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resethist = 1'b0; lvds_rx = '0; mask1 = '0; mask2 = '0; edgemode = 1'b1;
    passthrough = 1'b0; freeze = 1'b0; rd_req = 1'b0; rd_addr = '0; cyclestoveto = '0;

    // Reset state
    do_reset();
    chk("rst_out1", out1, 0); chk("rst_out2", out2, 0); chk("rst_inveto", inveto, 0);
    chk("rst_collision", collision, 0); chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);

    // Single ch2 pulse, 1-cycle latency
    mask1 = 8'h04;
    lvds_rx = 8'h04; chk("t1_out1_pre", out1, 0);
    step(); chk("t1_out1_hit", out1, 1);
    lvds_rx = '0; step(); chk("t1_out1_after", out1, 0);
    rd(2, 1, "t1_cnt2");
    lvds_rx = 8'h04;
    rd(2, 1, "t1_cnt2_collide");
    lvds_rx = '0;
    rd(2, 2, "t1_cnt2_post");
    drain();

    // Dead-time veto on ch0
    do_reset();
    mask1 = 8'h01; cyclestoveto = 8'd5;
    for (int c = 0; c < 12; c++) begin
      lvds_rx = (c == 0 || c == 3 || c == 10) ? 8'h01 : 8'h00;
      step();
      chk($sformatf("t2_collision_c%0d", c), collision, (c == 3));
      chk($sformatf("t2_out1_c%0d", c), out1, (c == 0 || c == 10));
      chk($sformatf("t2_inveto_c%0d", c), inveto, ((c >= 1 && c <= 5) || c == 11));
    end
    lvds_rx = '0;
    rd(NCH + 9, 1, "t2_ipi9");
    rd(0, 2, "t2_cnt0");
    rd(NCH + 2, 0, "t2_ipi2");
    rd(OVF, 0, "t2_ovf");
    drain();

    // Long gap -> overflow bin
    repeat (200) step();
    hold(8'h01, 1); step();
    rd(OVF, 1, "t3_ovf");
    rd(0, 3, "t3_cnt0");
    drain();

    // Level mode, held input, no veto
    do_reset();
    edgemode = 1'b0; cyclestoveto = '0;
    hold(8'h02, 10);
    rd(1, 10, "t3_cnt1_level");
    rd(NCH, 9, "t3_ipi0_level");
    rd(OVF, 0, "t3_ovf_level");
    drain();

    // Saturation at 2^CW-1
    do_reset();
    hold(8'h01, 254);
    rd(0, 254, "t4_cnt0_near");
    rd(NCH, 253, "t4_ipi0_near");
    drain();
    hold(8'h01, 3);
    rd(0, 255, "t4_cnt0_sat");
    rd(NCH, 255, "t4_ipi0_sat");
    rd(100, 0, "t4_addr100");
    rd(127, 0, "t4_addr127");
    drain();

    // Freeze: outputs run, counters hold
    do_reset();
    edgemode = 1'b1; mask1 = 8'h01; mask2 = 8'h01; freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lvds_rx = 8'h01; step();
      chk($sformatf("t5_out1_frz%0d", k), out1, 1);
      chk($sformatf("t5_out2_frz%0d", k), out2, 1);
      lvds_rx = '0; step(); step();
      chk($sformatf("t5_out1_idle%0d", k), out1, 0);
    end
    freeze = 1'b0;
    rd(0, 0, "t5_cnt0_frozen");
    rd(NCH + 2, 0, "t5_ipi2_frozen");
    drain();

    // Reset in the middle of a burst
    hold(8'h01, 1); step();
    hold(8'h01, 1);
    lvds_rx = 8'h01; resethist = 1'b1; step();
    resethist = 1'b0; lvds_rx = '0; step();
    rd(0, 0, "t5_cnt0_after_rst");
    rd(NCH + 1, 0, "t5_ipi1_after_rst");
    rd(OVF, 0, "t5_ovf_after_rst");
    drain();
    hold(8'h01, 1); step();
    rd(0, 1, "t5_cnt0_first");
    rd(OVF, 0, "t5_ovf_first");
    drain();

    // Passthrough
    do_reset();
    passthrough = 1'b1; mask1 = 8'h00; mask2 = 8'h80; lvds_rx = 8'h81;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t6_out2_c%0d", k), out2, 1);
      chk($sformatf("t6_out1_c%0d", k), out1, 0);
    end
    passthrough = 1'b0; lvds_rx = '0; step();
    chk("t6_out2_off", out2, 0);
    rd(0, 0, "t6_cnt0");
    rd(7, 0, "t6_cnt7");
    rd(OVF, 0, "t6_ovf");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
